// File: rtl/light_conflict_monitor_if.sv
// rtl/light_conflict_monitor_if.sv - lamp inputs, clear request and status outputs of the conflict monitor
interface light_conflict_monitor_if;
    logic       RA, YA, GA;
    logic       RB, YB, GB;
    logic       clr_fault;
    logic       armed;
    logic       fault;
    logic [2:0] fault_code;
    logic       fault_app;
    logic       flash;

    modport master (
        output RA, YA, GA, RB, YB, GB, clr_fault,
        input  armed, fault, fault_code, fault_app, flash
    );

    modport slave (
        input  RA, YA, GA, RB, YB, GB, clr_fault,
        output armed, fault, fault_code, fault_app, flash
    );
endinterface

// File: rtl/light_conflict_monitor.sv
// rtl/light_conflict_monitor.sv - two-approach traffic lamp conflict monitor with latched fault cause and flash drive
module light_conflict_monitor #(
    parameter int MIN_YELLOW = 1,
    parameter int FLASH_DIV  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    light_conflict_monitor_if.slave  mon
);
    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    localparam logic [2:0] C_R = 3'b100;
    localparam logic [2:0] C_Y = 3'b010;
    localparam logic [2:0] C_G = 3'b001;

    typedef enum logic [1:0] {ARM, MONITOR, FAULT} state_t;

    state_t          state, state_next;
    logic [2:0]      cur_a, cur_b, prev_a, prev_b;
    logic [YW-1:0]   ycnt_a, ycnt_b;
    logic [FW-1:0]   fcnt, fcnt_next;
    logic [2:0]      viol_code, code_q, code_next;
    logic            viol_app, app_q, app_next;
    logic            armed_q, fault_q, flash_q, flash_next;

    assign cur_a = {mon.RA, mon.YA, mon.GA};
    assign cur_b = {mon.RB, mon.YB, mon.GB};

    function automatic logic legal(input logic [2:0] c);
        return (c == C_R) || (c == C_Y) || (c == C_G);
    endfunction

    // Only G->Y, Y->R and R->G are permitted colour changes
    function automatic logic bad_seq(input logic [2:0] p, input logic [2:0] c);
        return legal(p) && legal(c) && (p != c) &&
               !((p == C_G && c == C_Y) || (p == C_Y && c == C_R) || (p == C_R && c == C_G));
    endfunction

    // Lowest code wins; within a code approach A is reported before B
    always_comb begin
        viol_code = 3'd0;
        viol_app  = 1'b0;
        if (!legal(cur_a)) begin
            viol_code = 3'd1;
        end else if (!legal(cur_b)) begin
            viol_code = 3'd1;
            viol_app  = 1'b1;
        end else if (cur_a != C_R && cur_b != C_R) begin
            viol_code = 3'd2;
        end else if (state == MONITOR) begin
            if (bad_seq(prev_a, cur_a)) begin
                viol_code = 3'd3;
            end else if (bad_seq(prev_b, cur_b)) begin
                viol_code = 3'd3;
                viol_app  = 1'b1;
            end else if (prev_a == C_Y && cur_a == C_R && ycnt_a < YW'(MIN_YELLOW)) begin
                viol_code = 3'd4;
            end else if (prev_b == C_Y && cur_b == C_R && ycnt_b < YW'(MIN_YELLOW)) begin
                viol_code = 3'd4;
                viol_app  = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        code_next  = code_q;
        app_next   = app_q;
        case (state)
            ARM: begin
                if (viol_code != 3'd0) begin
                    state_next = FAULT;
                    code_next  = viol_code;
                    app_next   = viol_app;
                end else if (legal(cur_a) && legal(cur_b) && (cur_a == C_R || cur_b == C_R)) begin
                    state_next = MONITOR;
                end
            end
            MONITOR: begin
                if (viol_code != 3'd0) begin
                    state_next = FAULT;
                    code_next  = viol_code;
                    app_next   = viol_app;
                end
            end
            FAULT: begin
                // Only codes 1 and 2 are evaluated here, so a clean code means safe to re-arm
                if (mon.clr_fault && viol_code == 3'd0) begin
                    state_next = ARM;
                    code_next  = 3'd0;
                    app_next   = 1'b0;
                end
            end
            default: state_next = ARM;
        endcase
    end

    always_comb begin
        flash_next = 1'b0;
        fcnt_next  = '0;
        if (state_next == FAULT) begin
            if (state != FAULT) begin
                flash_next = 1'b1;
            end else if (fcnt == FW'(FLASH_DIV - 1)) begin
                flash_next = ~flash_q;
            end else begin
                flash_next = flash_q;
                fcnt_next  = fcnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ARM;
            armed_q <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= 3'd0;
            app_q   <= 1'b0;
            flash_q <= 1'b0;
            fcnt    <= '0;
            prev_a  <= 3'd0;
            prev_b  <= 3'd0;
            ycnt_a  <= '0;
            ycnt_b  <= '0;
        end else begin
            state   <= state_next;
            armed_q <= (state_next == MONITOR);
            fault_q <= (state_next == FAULT);
            code_q  <= code_next;
            app_q   <= app_next;
            flash_q <= flash_next;
            fcnt    <= fcnt_next;
            prev_a  <= cur_a;
            prev_b  <= cur_b;
            if (cur_a != C_Y)                   ycnt_a <= '0;
            else if (ycnt_a != YW'(MIN_YELLOW)) ycnt_a <= ycnt_a + YW'(1);
            if (cur_b != C_Y)                   ycnt_b <= '0;
            else if (ycnt_b != YW'(MIN_YELLOW)) ycnt_b <= ycnt_b + YW'(1);
        end
    end

    assign mon.armed      = armed_q;
    assign mon.fault      = fault_q;
    assign mon.fault_code = code_q;
    assign mon.fault_app  = app_q;
    assign mon.flash      = flash_q;
endmodule

// File: tb/tb_light_conflict_monitor.sv
// tb/tb_light_conflict_monitor.sv - scoreboard bench for light_conflict_monitor at two parameter sets
module tb_light_conflict_monitor;
    typedef struct packed {
        logic       armed;
        logic       fault;
        logic [2:0] code;
        logic       app;
        logic       flash;
    } exp_t;

    localparam int ST_ARM = 0, ST_MON = 1, ST_FAULT = 2;
    localparam logic [5:0] GA_RB  = 6'b001_100;
    localparam logic [5:0] YA_RB  = 6'b010_100;
    localparam logic [5:0] RA_GB  = 6'b100_001;
    localparam logic [5:0] RA_YB  = 6'b100_010;
    localparam logic [5:0] RA_RB  = 6'b100_100;
    localparam logic [5:0] GA_GB  = 6'b001_001;
    localparam logic [5:0] GYA_GB = 6'b011_001;

    logic clk;
    logic rst;
    light_conflict_monitor_if m0();
    light_conflict_monitor_if m1();

    light_conflict_monitor dut0 (.clk(clk), .rst(rst), .mon(m0));
    light_conflict_monitor #(.MIN_YELLOW(3), .FLASH_DIV(2)) dut1 (.clk(clk), .rst(rst), .mon(m1));

    int   my[2] = '{1, 3};
    int   fd[2] = '{4, 2};
    int   m_state[2];
    int   m_code[2];
    int   m_app[2];
    int   m_fcnt[2];
    byte  m_prev[2][2];
    int   m_yrun[2][2];
    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   failures = 0;
    logic [5:0] cur_lamps;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int d, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0d expected=%0d at %0t", name, d, act, expv, $time);
        end
    endtask

    function automatic byte colour(input logic r, input logic y, input logic g);
        if ({r, y, g} == 3'b100) return "R";
        if ({r, y, g} == 3'b010) return "Y";
        if ({r, y, g} == 3'b001) return "G";
        return "X";
    endfunction

    function automatic bit step_ok(input byte p, input byte c);
        return (p == c) || (p == "G" && c == "Y") || (p == "Y" && c == "R") || (p == "R" && c == "G");
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = ST_ARM;
            m_code[i] = 0;
            m_app[i] = 0;
            m_fcnt[i] = 0;
            for (int k = 0; k < 2; k++) begin
                m_prev[i][k] = "X";
                m_yrun[i][k] = 0;
            end
        end
    endtask

    task automatic model_step(input int i, input logic [5:0] l, input logic clr, output exp_t e);
        byte c[2];
        int code, app;
        c[0] = colour(l[5], l[4], l[3]);
        c[1] = colour(l[2], l[1], l[0]);
        code = 0;
        app = 0;
        if (c[0] == "X") code = 1;
        else if (c[1] == "X") begin code = 1; app = 1; end
        else if (c[0] != "R" && c[1] != "R") code = 2;
        else if (m_state[i] == ST_MON) begin
            for (int k = 0; k < 2; k++)
                if (code == 0 && m_prev[i][k] != "X" && !step_ok(m_prev[i][k], c[k])) begin
                    code = 3; app = k;
                end
            for (int k = 0; k < 2; k++)
                if (code == 0 && m_prev[i][k] == "Y" && c[k] == "R" && m_yrun[i][k] < my[i]) begin
                    code = 4; app = k;
                end
        end
        if (m_state[i] == ST_FAULT) begin
            if (clr && code == 0) begin
                m_state[i] = ST_ARM;
                m_code[i] = 0;
                m_app[i] = 0;
            end else begin
                m_fcnt[i]++;
            end
        end else if (code != 0) begin
            m_state[i] = ST_FAULT;
            m_code[i] = code;
            m_app[i] = app;
            m_fcnt[i] = 0;
        end else begin
            m_state[i] = ST_MON;
        end
        for (int k = 0; k < 2; k++) begin
            m_yrun[i][k] = (c[k] == "Y") ? m_yrun[i][k] + 1 : 0;
            m_prev[i][k] = c[k];
        end
        e.armed = (m_state[i] == ST_MON);
        e.fault = (m_state[i] == ST_FAULT);
        e.code  = 3'(m_code[i]);
        e.app   = m_app[i][0];
        e.flash = (m_state[i] == ST_FAULT) && ((m_fcnt[i] / fd[i]) % 2 == 0);
    endtask

    task automatic set_inputs(input logic [5:0] l, input logic clr);
        {m0.RA, m0.YA, m0.GA, m0.RB, m0.YB, m0.GB} = l;
        {m1.RA, m1.YA, m1.GA, m1.RB, m1.YB, m1.GB} = l;
        m0.clr_fault = clr;
        m1.clr_fault = clr;
        cur_lamps = l;
    endtask

    task automatic push_expect(input logic [5:0] l, input logic clr);
        exp_t e;
        model_step(0, l, clr, e);
        q0.push_back(e);
        model_step(1, l, clr, e);
        q1.push_back(e);
    endtask

    task automatic drive(input logic [5:0] l, input logic clr);
        @(negedge clk);
        set_inputs(l, clr);
        push_expect(l, clr);
    endtask

    // Asynchronous reset: outputs must drop before any clock edge
    task automatic do_reset();
        @(negedge clk);
        set_inputs(RA_RB, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_armed", 0, int'(m0.armed), 0);
        chk("rst_fault", 0, int'(m0.fault), 0);
        chk("rst_code",  0, int'(m0.fault_code), 0);
        chk("rst_app",   0, int'(m0.fault_app), 0);
        chk("rst_flash", 0, int'(m0.flash), 0);
        chk("rst_fault", 1, int'(m1.fault), 0);
        chk("rst_code",  1, int'(m1.fault_code), 0);
        chk("rst_flash", 1, int'(m1.flash), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        push_expect(RA_RB, 1'b0);
    endtask

    task automatic compare(input int d, input exp_t e);
        if (d == 0) begin
            chk("armed", 0, int'(m0.armed), int'(e.armed));
            chk("fault", 0, int'(m0.fault), int'(e.fault));
            chk("fault_code", 0, int'(m0.fault_code), int'(e.code));
            chk("fault_app", 0, int'(m0.fault_app), int'(e.app));
            chk("flash", 0, int'(m0.flash), int'(e.flash));
        end else begin
            chk("armed", 1, int'(m1.armed), int'(e.armed));
            chk("fault", 1, int'(m1.fault), int'(e.fault));
            chk("fault_code", 1, int'(m1.fault_code), int'(e.code));
            chk("fault_app", 1, int'(m1.fault_app), int'(e.app));
            chk("flash", 1, int'(m1.flash), int'(e.flash));
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                compare(0, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                compare(1, e);
            end
        end
    end

    initial begin : stimulus
        logic [5:0] phases[4];
        int ph, dwell;
        phases[0] = GA_RB;
        phases[1] = YA_RB;
        phases[2] = RA_GB;
        phases[3] = RA_YB;
        rst = 1'b0;
        set_inputs(6'b0, 1'b0);
        model_reset();
        do_reset();

        for (int r = 0; r < 20; r++)
            for (int p = 0; p < 4; p++) drive(phases[p], 1'b0);
        drive(GA_RB, 1'b0);

        drive(GA_GB, 1'b0);
        for (int n = 0; n < 10; n++) drive(GA_GB, 1'b0);
        drive(RA_RB, 1'b1);
        drive(RA_RB, 1'b0);

        drive(RA_RB, 1'b0);
        drive(RA_YB, 1'b0);
        drive(RA_YB, 1'b0);
        drive(RA_RB, 1'b1);
        drive(RA_RB, 1'b0);

        drive(GA_RB, 1'b0);
        drive(YA_RB, 1'b0);
        drive(YA_RB, 1'b0);
        drive(RA_RB, 1'b0);
        drive(RA_RB, 1'b1);
        drive(RA_RB, 1'b1);
        drive(GA_RB, 1'b0);
        for (int n = 0; n < 3; n++) drive(YA_RB, 1'b0);
        drive(RA_RB, 1'b0);

        drive(GYA_GB, 1'b0);
        drive(GYA_GB, 1'b1);
        drive(GA_GB, 1'b1);
        drive(RA_RB, 1'b1);
        drive(RA_RB, 1'b0);

        drive(GA_GB, 1'b0);
        drive(GA_GB, 1'b0);
        do_reset();

        ph = 0;
        dwell = 1;
        for (int n = 0; n < 600; n++) begin
            int sel;
            logic clr;
            if (n == 300) do_reset();
            sel = int'($urandom_range(0, 15));
            clr = ($urandom_range(0, 5) == 0);
            if (sel == 0) drive(6'($urandom), clr);
            else if (sel == 1) drive(RA_RB, clr);
            else begin
                drive(phases[ph], clr);
                dwell--;
                if (dwell == 0) begin
                    ph = (ph + 1) % 4;
                    dwell = int'($urandom_range(1, 4));
                end
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 0, q0.size() + q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/light_conflict_monitor.md
LIGHT_CONFLICT_MONITOR -- requirements
Module: light_conflict_monitor

Interface
REQ-001 Parameter MIN_YELLOW, default 1: minimum consecutive yellow cycles before an approach may go red.
REQ-002 Parameter FLASH_DIV, default 4: cycles per half-period of the flash output in FAULT.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 RA, YA, GA  input  1 each  approach A red/yellow/green lamp drives, as produced by the light controller.
REQ-006 RB, YB, GB  input  1 each  approach B red/yellow/green lamp drives.
REQ-007 clr_fault  input  1  synchronous request to leave FAULT.
REQ-008 armed  output  1  high while in MONITOR.
REQ-009 fault  output  1  high while in FAULT.
REQ-010 fault_code  output  3  cause of the latched fault; 0 when no fault.
REQ-011 fault_app  output  1  approach that caused the fault: 0=A, 1=B.
REQ-012 flash  output  1  blink drive for all-red flashing while in FAULT; 0 otherwise.

Function
REQ-013 The FSM SHALL have three states: ARM, MONITOR, FAULT.
REQ-014 Per approach, "legal" SHALL mean exactly one of R/Y/G is high; "red" SHALL mean legal and R high.
REQ-015 Code 1 (lamp error): an approach is not legal; fault_app = first illegal approach, A before B.
REQ-016 Code 2 (conflict): both approaches legal and neither red; fault_app = 0.
REQ-017 Code 3 (bad sequence): an approach changes colour other than G->Y, Y->R or R->G (e.g. G->R, Y->G, R->Y).
REQ-018 Code 4 (short yellow): an approach goes Y->R after fewer than MIN_YELLOW consecutive yellow cycles.
REQ-019 If several violations hold in one cycle, the lowest code SHALL be reported; within a code, A before B.
REQ-020 Lamps SHALL be sampled every edge into previous-colour registers; codes 3 and 4 compare current inputs with those registers.
REQ-021 Each approach SHALL have a yellow counter: cleared when not yellow, incremented while yellow, saturating at MIN_YELLOW.
REQ-022 ARM->MONITOR SHALL occur on the first edge at which both approaches are legal and at least one is red; codes 3 and 4 are not checked in ARM.
REQ-023 ARM SHALL enter FAULT on code 1 or code 2.
REQ-024 MONITOR->FAULT SHALL occur on the edge at which any code 1-4 is detected. fault, fault_code and fault_app become visible one cycle after the violating inputs are applied.
REQ-025 In FAULT, fault_code and fault_app SHALL hold their values; later violations SHALL NOT overwrite them.
REQ-026 FAULT->ARM SHALL occur when clr_fault is high and the current inputs show no code 1 or code 2; otherwise the block stays in FAULT.
REQ-027 On leaving FAULT, fault_code SHALL clear to 0.
REQ-028 If clr_fault is high in ARM or MONITOR, it SHALL be ignored.
REQ-029 If a violation and clr_fault coincide in MONITOR, the violation SHALL win.
REQ-030 On FAULT entry, flash SHALL go to 1 and the flash counter to 0. The counter counts 0..FLASH_DIV-1; flash toggles on each wrap.
REQ-031 Outside FAULT, flash SHALL be 0 and the flash counter SHALL be held at 0.
REQ-032 armed = (state==MONITOR) and fault = (state==FAULT), both registered.

Reset
REQ-033 When rst is low: state=ARM; armed=0, fault=0, fault_code=0, fault_app=0, flash=0; yellow counters, flash counter and previous-colour registers cleared to 0. This SHALL take effect immediately, without waiting for clk.
REQ-034 Reset asserted mid-FAULT or mid-MONITOR SHALL discard the latched cause.
REQ-035 After rst deasserts, the first active edge SHALL evaluate ARM rules.

Verification
REQ-036 Legal cycle, default parameters: lamps GA+RB, YA+RB, RA+GB, RA+YB, GA+RB repeated 20 times -> armed=1 from cycle 2; fault stays 0 throughout.
REQ-037 Conflict: while armed, drive GA+GB -> next cycle fault=1, fault_code=2, fault_app=0, flash=1; flash toggles every 4 cycles.
REQ-038 Sequence: while armed, drive B R->Y (RA+RB then RA+YB) -> fault_code=3, fault_app=1.
REQ-039 MIN_YELLOW=3: A yellow for 2 cycles then red -> fault_code=4, fault_app=0. A yellow for 3 cycles then red -> no fault.
REQ-040 Priority and clear: drive GA+YA with GB in the same cycle -> fault_code=1 (not 2). Then clr_fault=1 while lamps are still illegal -> stays in FAULT. Then lamps RA+RB with clr_fault=1 -> ARM next cycle with fault_code=0, then MONITOR the following cycle.
REQ-041 Reset mid-fault: rst low while fault=1 -> all outputs 0 immediately, without waiting for clk; state ARM after release.
